secp256k1_mult_resp: RTL and testbench
======================================

# secp256k1_mult_resp

Responder side of the 256-bit modular-multiply request/response stream that secp256k1 point arithmetic blocks issue. Accepts one tagged request `{b, a}` with a `ctl` tag, computes `a*b mod p` for `p = 2^256 - 2^32 - 977` with an iterative MSB-first interleaved multiply, and returns the 256-bit result with the tag echoed. It sits between the point-arithmetic initiators and the result stream they consume. It is single-in-flight and carries no DSP dependency.

## Interface
- `CTL_BITS`, default 8: width of the request/response tag.
- `i_clk` in, 1: clock.
- `i_rst` in, 1: reset. One clock; reset is synchronous and active-low.
- `i_mul_if` sink, if_axi_stream: request stream.
  - `dat[255:0]` = a, `dat[511:256]` = b.
  - `ctl[CTL_BITS-1:0]` is the tag.
  - Uses `val` and `rdy`; other fields are ignored.
- `o_res_if` source, if_axi_stream: response stream.
  - `dat[255:0]` is the result; upper bits are 0.
  - `ctl` is the echoed tag.
  - `sop=eop=1` whenever `val` is high.
  - `err` is described under Configuration.

## Operation
- States: IDLE, LOAD, MUL, DONE.
- **IDLE**
  - `i_mul_if.rdy` = 1.
  - On `val && rdy`, latch a, b and ctl, drop `rdy`, and go to LOAD.
- **LOAD** (1 cycle)
  - `a_r = (a >= p) ? a - p : a`. A single subtract suffices because a < 2^256 < 2p.
  - `acc` = 0, bit counter = 255.
  - Go to MUL.
- **MUL** (256 cycles, one bit of b per cycle, b[255] first)
  - `t = 2*acc + (b[i] ? a_r : 0)`, computed 258 bits wide. t < 3p.
  - Subtract p up to twice: `t >= 2p` gives t-2p; else `t >= p` gives t-p.
  - `acc` <= the reduced value. Invariant: acc < p.
  - On the cycle with counter = 0:
    - `o_res_if.dat` <= reduced value;
    - `o_res_if.ctl` <= tag;
    - `o_res_if.val` <= 1;
    - go to DONE.
- **DONE**
  - Hold `val`, `dat`, `ctl` and `err` stable.
  - On `o_res_if.rdy`: `val` <= 0, `i_mul_if.rdy` <= 1, go to IDLE.
- b is used bitwise only, so b >= p needs no pre-reduction: the result equals `a*b mod p` for any 256-bit b.
- Output is always fully reduced: < p.
- Requests presented while not in IDLE are not accepted. Initiators hold `val` until accepted.

## Timing
- Reset (`i_rst` low at an edge, in any state, including mid-MUL):
  - go to IDLE;
  - `i_mul_if.rdy`=0, `o_res_if.val`=0, `dat`=0, `ctl`=0, `err`=0, `sop`=`eop`=0;
  - counter and `acc` = 0;
  - the in-flight request is discarded with no response.
- First edge after reset release: `i_mul_if.rdy` goes to 1.
- Latency: accept on edge E0. LOAD registers at E1, MUL at E2..E257. `o_res_if.val` is high after E257, i.e. 257 cycles after acceptance.
- Output handshake at edge En also sets `i_mul_if.rdy`=1 at En. Earliest next accept is En+1. Throughput: 1 result per 259 cycles with no back-pressure.
- `o_res_if.rdy` low in DONE: stall indefinitely with outputs unchanged.

## Configuration
- `SECP256K1_MULT_RESP_CHK_EN` defined:
  - at acceptance, compare a >= p and b >= p;
  - if either holds, the response carries `o_res_if.err`=1;
  - the result is still computed as specified (a pre-reduced);
  - `err` clears with `val` on the output handshake.
- Undefined: comparators are not built and `o_res_if.err` is tied 0.

## Test plan
- a=2, b=3, ctl=0x05, `o_res_if.rdy`=1 -> `dat`=6, `ctl`=0x05, `val` rises exactly 257 cycles after the accept edge, `val` high for 1 cycle, `i_mul_if.rdy` high the following cycle.
- a=p-1, b=p-1 -> `dat`=1. Then a=p+5, b=2 -> `dat`=10 (LOAD pre-reduction).
- Back-pressure: after result of a=7, b=9, hold `o_res_if.rdy`=0 for 20 cycles -> `dat`=63 and `ctl` stable, `i_mul_if.rdy`=0 throughout. Release -> one handshake, next request accepted on the following edge.
- Reset mid-MUL (`i_rst` low 2 cycles at cycle 100 after accept) -> `val`=0, no response for the aborted tag, `rdy`=1 one edge after release. New request a=0, b=0x1234, ctl=0x11 -> `dat`=0, `ctl`=0x11.
- Random: 200 requests with random a, b (including 0, 1, p-1, 2^256-1) -> each `dat` matches the reference model `a*b mod p` and tags return in order.
- With `SECP256K1_MULT_RESP_CHK_EN`: a=5, b=p -> `dat`=0, `err`=1. a=5, b=3 -> `dat`=15, `err`=0. Without the macro, both give `err`=0.

Source files
------------

// File: rtl/secp256k1_mult_resp.sv
// secp256k1 modular-multiply responder: a*b mod p, p = 2^256 - 2^32 - 977, MSB-first interleaved.
// Optional: define SECP256K1_MULT_RESP_CHK_EN to flag unreduced operands on o_res_if_err.
module secp256k1_mult_resp #(
    parameter int CTL_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [511:0]        i_mul_if_dat,
    input  logic [CTL_BITS-1:0] i_mul_if_ctl,
    input  logic                i_mul_if_val,
    output logic                i_mul_if_rdy,
    output logic [511:0]        o_res_if_dat,
    output logic [CTL_BITS-1:0] o_res_if_ctl,
    output logic                o_res_if_val,
    output logic                o_res_if_sop,
    output logic                o_res_if_eop,
    output logic                o_res_if_err,
    input  logic                o_res_if_rdy
);
    localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [257:0] P1 = {2'b00, P};
    localparam logic [257:0] P2 = {1'b0, P, 1'b0};

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;

    state_t              state_q, state_d;
    logic                rdy_q, rdy_d;
    logic [255:0]        a_q, a_d, b_q, b_d, acc_q, acc_d, dat_q, dat_d;
    logic [CTL_BITS-1:0] tag_q, tag_d, ctl_q, ctl_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                val_q, val_d;
    logic                accept;
    logic [257:0]        t, red;

    assign accept = (state_q == IDLE) && rdy_q && i_mul_if_val;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            dat_q   <= '0;
            tag_q   <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            dat_q   <= dat_d;
            tag_q   <= tag_d;
            ctl_q   <= ctl_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: state_d = MUL;
            MUL:  if (cnt_q == 8'd0) state_d = DONE;
            DONE: if (o_res_if_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 2*acc + a_r < 3p, so at most two conditional subtractions restore acc < p
    always_comb begin
        t = {1'b0, acc_q, 1'b0} + (b_q[cnt_q] ? {2'b00, a_q} : 258'd0);
        if (t >= P2)      red = t - P2;
        else if (t >= P1) red = t - P1;
        else              red = t;
    end

    always_comb begin
        rdy_d = (state_q == IDLE && !accept) || (state_q == DONE && o_res_if_rdy);
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        dat_d = dat_q;
        tag_d = tag_q;
        ctl_d = ctl_q;
        cnt_d = cnt_q;
        val_d = val_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d   = i_mul_if_dat[255:0];
                b_d   = i_mul_if_dat[511:256];
                tag_d = i_mul_if_ctl;
            end
            LOAD: begin
                a_d   = (a_q >= P) ? a_q - P : a_q;
                acc_d = '0;
                cnt_d = 8'd255;
            end
            MUL: begin
                acc_d = 256'(red);
                if (cnt_q == 8'd0) begin
                    dat_d = 256'(red);
                    ctl_d = tag_q;
                    val_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: if (o_res_if_rdy) val_d = 1'b0;
            default: ;
        endcase
    end

`ifdef SECP256K1_MULT_RESP_CHK_EN
    logic errp_q, errp_d, err_q, err_d;

    always_comb begin
        errp_d = errp_q;
        err_d  = err_q;
        if (accept) errp_d = (i_mul_if_dat[255:0] >= P) || (i_mul_if_dat[511:256] >= P);
        if (state_q == MUL && cnt_q == 8'd0) err_d = errp_q;
        if (state_q == DONE && o_res_if_rdy) err_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            errp_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            errp_q <= errp_d;
            err_q  <= err_d;
        end
    end

    assign o_res_if_err = err_q;
`else
    assign o_res_if_err = 1'b0;
`endif

    assign i_mul_if_rdy = rdy_q;
    assign o_res_if_dat = {256'd0, dat_q};
    assign o_res_if_ctl = ctl_q;
    assign o_res_if_val = val_q;
    assign o_res_if_sop = val_q;
    assign o_res_if_eop = val_q;
endmodule

// File: tb/tb_secp256k1_mult_resp.sv
// Scoreboard bench for secp256k1_mult_resp; reference result is a full 512-bit product mod p.
module tb_secp256k1_mult_resp;
    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_dat;
    logic [7:0]   in_ctl;
    logic         in_val;
    logic         in_rdy;
    logic [511:0] out_dat;
    logic [7:0]   out_ctl;
    logic         out_val, out_sop, out_eop, out_err;
    logic         out_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accept_cyc;
    logic [255:0] P;
    logic [511:0] P512;
    logic [255:0] exp_dat_q[$];
    logic [7:0]   exp_ctl_q[$];
    logic         exp_err_q[$];

    secp256k1_mult_resp #(.CTL_BITS(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mul_if_dat(in_dat), .i_mul_if_ctl(in_ctl), .i_mul_if_val(in_val), .i_mul_if_rdy(in_rdy),
        .o_res_if_dat(out_dat), .o_res_if_ctl(out_ctl), .o_res_if_val(out_val),
        .o_res_if_sop(out_sop), .o_res_if_eop(out_eop), .o_res_if_err(out_err), .o_res_if_rdy(out_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod;
        prod = {256'd0, a} * {256'd0, b};
        return 256'(prod % P512);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and hold val until the DUT accepts it; optionally record the expected response.
    task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [7:0] c, input bit push);
        bit done = 0;
        if (push) begin
            exp_dat_q.push_back(ref_mul(a, b));
            exp_ctl_q.push_back(c);
`ifdef SECP256K1_MULT_RESP_CHK_EN
            exp_err_q.push_back((a >= P) || (b >= P));
`else
            exp_err_q.push_back(1'b0);
`endif
        end
        in_dat = {b, a};
        in_ctl = c;
        in_val = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            if (in_rdy) begin
                accept_cyc = cyc + 1;
                done = 1;
            end
            tick();
        end
        in_val = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout ctl=%h rdy never seen", c);
        end
    endtask

    // Wait for a response, compare to scoreboard head; optionally check latency and post-handshake state.
    task automatic recv(input bit chk_lat, input bit chk_after);
        bit got = 0;
        int lat;
        logic [255:0] ed;
        logic [7:0]   ec;
        logic         ee;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (out_val) got = 1;
        end
        total++;
        if (!got || exp_dat_q.size() == 0) begin
            bad++;
            $display("FAIL recv_timeout got_val=%0d pending=%0d", got, exp_dat_q.size());
            return;
        end
        lat = cyc - accept_cyc;
        ed = exp_dat_q.pop_front();
        ec = exp_ctl_q.pop_front();
        ee = exp_err_q.pop_front();
        if (out_dat !== {256'd0, ed}) begin
            bad++; $display("FAIL dat got=%h want=%h", out_dat, ed);
        end
        total++;
        if (out_ctl !== ec) begin
            bad++; $display("FAIL ctl got=%h want=%h", out_ctl, ec);
        end
        total++;
        if (out_err !== ee) begin
            bad++; $display("FAIL err got=%b want=%b", out_err, ee);
        end
        total++;
        if (out_sop !== 1'b1 || out_eop !== 1'b1) begin
            bad++; $display("FAIL sop_eop got=%b%b want=11", out_sop, out_eop);
        end
        if (chk_lat) begin
            total++;
            if (lat !== 257) begin
                bad++; $display("FAIL latency got=%0d want=257", lat);
            end
        end
        if (chk_after) begin
            tick();
            total++;
            if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
                bad++; $display("FAIL post_hs val=%b rdy=%b want val=0 rdy=1", out_val, in_rdy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({in_rdy, out_val, out_err, out_sop, out_eop} !== 5'b0 || out_dat !== 512'd0 || out_ctl !== 8'd0) begin
            bad++;
            $display("FAIL reset_state rdy=%b val=%b err=%b sop=%b eop=%b ctl=%h want all 0",
                     in_rdy, out_val, out_err, out_sop, out_eop, out_ctl);
        end
        rst = 1'b1;
        tick();
        total++;
        if (in_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_release_rdy got=%b want=1", in_rdy);
        end
    endtask

    task automatic test_basic();
        send(256'd2, 256'd3, 8'h05, 1);
        recv(1, 1);
    endtask

    task automatic test_boundary();
        send(P - 256'd1, P - 256'd1, 8'h21, 1);
        recv(1, 1);
        send(P + 256'd5, 256'd2, 8'h22, 1);
        recv(1, 1);
    endtask

    task automatic test_backpressure();
        int hs;
        bit stable = 1;
        out_rdy = 1'b0;
        send(256'd7, 256'd9, 8'h33, 0);
        for (int i = 0; i < 600 && !out_val; i++) tick();
        for (int i = 0; i < 20; i++) begin
            if (out_val !== 1'b1 || out_dat !== 512'd63 || out_ctl !== 8'h33 || in_rdy !== 1'b0) stable = 0;
            tick();
        end
        total++;
        if (!stable) begin
            bad++; $display("FAIL bp_stall val=%b dat=%h ctl=%h rdy=%b want 1/63/33/0", out_val, out_dat, out_ctl, in_rdy);
        end
        out_rdy = 1'b1;
        tick();
        hs = cyc;
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            bad++; $display("FAIL bp_release val=%b rdy=%b want 0/1", out_val, in_rdy);
        end
        send(256'd4, 256'd4, 8'h34, 1);
        total++;
        if (accept_cyc !== hs + 1) begin
            bad++; $display("FAIL bp_next_accept got=%0d want=%0d", accept_cyc, hs + 1);
        end
        recv(0, 1);
    endtask

    task automatic test_reset_mid_mul();
        send(256'd123, 256'd456, 8'h77, 0);
        repeat (99) tick();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b0) begin
            bad++; $display("FAIL midrst_state val=%b rdy=%b want 0/0", out_val, in_rdy);
        end
        rst = 1'b1;
        tick();
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            bad++; $display("FAIL midrst_release rdy=%b val=%b want 1/0", in_rdy, out_val);
        end
        send(256'd0, 256'h1234, 8'h11, 1);
        recv(1, 1);
    endtask

    task automatic test_random();
        logic [255:0] a, b;
        logic [255:0] sp[4];
        sp[0] = 256'd0;
        sp[1] = 256'd1;
        sp[2] = P - 256'd1;
        sp[3] = '1;
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 8; k++) begin
                a[k*32 +: 32] = $urandom;
                b[k*32 +: 32] = $urandom;
            end
            if (n % 5 == 0) a = sp[$urandom_range(0, 3)];
            if (n % 7 == 0) b = sp[$urandom_range(0, 3)];
            if (n < 16) begin
                a = sp[n % 4];
                b = sp[n / 4];
            end
            send(a, b, 8'(n), 1);
            recv(0, 0);
        end
        tick();
    endtask

    task automatic test_chk();
        send(256'd5, P, 8'h41, 1);
        recv(0, 1);
        send(256'd5, 256'd3, 8'h42, 1);
        recv(0, 1);
    endtask

    initial begin
        P512 = (512'd1 << 256) - (512'd1 << 32) - 512'd977;
        P = P512[255:0];
        rst = 1'b0;
        in_dat = '0;
        in_ctl = '0;
        in_val = 1'b0;
        out_rdy = 1'b1;
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_mid_mul();
        test_chk();
        test_random();
        total++;
        if (exp_dat_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_dat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
